mem_1r1w_pipe: RTL and testbench



---
 rtl/mem_lower_pkg.sv | 29 ++
 rtl/mem_1r1w_array.sv | 46 ++++
 rtl/mem_1r1w_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_mem_1r1w_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lower_pkg.sv
// Shared helpers and types for the lowered 1R1W memory wrappers.
// Sizing functions, fill FSM state encoding and latency limit.
package mem_lower_pkg;

  localparam int MAX_READ_LATENCY = 4;

  typedef enum logic {
    CLEAR,
    RUN
  } fill_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r++;
    end
    return r;
  endfunction

  function automatic int addr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int mask_w(input int width, input int gran);
    return width / gran;
  endfunction

endpackage

// File: rtl/mem_1r1w_array.sv
// Plain 1R1W storage: lane-masked synchronous write, registered read.
// Behavioural model; an XPM macro can be dropped in behind the same ports.
module mem_1r1w_array
  import mem_lower_pkg::*;
#(
  parameter int DEPTH = 48,
  parameter int WIDTH = 64,
  parameter int MASK_GRAN = 8,
  localparam int ADDR_W = addr_w(DEPTH),
  localparam int MASK_W = mask_w(WIDTH, MASK_GRAN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [MASK_W-1:0] wmask,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // masked write: only enabled lanes of the addressed word change
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (wmask[i]) begin
          mem[waddr][i*MASK_GRAN +: MASK_GRAN] <=
            wdata[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // registered read; holds its value between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mem_1r1w_pipe.sv
// 1R1W memory with zero-fill sequencer, lane masks and read pipeline.
// Optional same-cycle write-to-read forwarding: MEM_1R1W_BYPASS_EN.
module mem_1r1w_pipe
  import mem_lower_pkg::*;
#(
  parameter int DEPTH = 48,
  parameter int WIDTH = 64,
  parameter int MASK_GRAN = 8,
  parameter int READ_LATENCY = 1,
  localparam int ADDR_W = addr_w(DEPTH),
  localparam int MASK_W = mask_w(WIDTH, MASK_GRAN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [WIDTH-1:0]  R0_data,
  output logic              R0_valid,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic [MASK_W-1:0] W0_mask,
  output logic              init_busy
);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_lat
    $error("mem_1r1w_pipe: READ_LATENCY out of range");
  end
  if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
    $error("mem_1r1w_pipe: MASK_GRAN must divide WIDTH");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("mem_1r1w_pipe: DEPTH must be at least 2");
  end

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  fill_state_e       state;
  fill_state_e       state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  logic              run;
  logic              w_in;
  logic              r_in;
  logic              rd_fire;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [WIDTH-1:0]  arr_wdata;
  logic [MASK_W-1:0] arr_wmask;
  logic              arr_re;
  logic [WIDTH-1:0]  rd_q;

  logic              oor_q;
  logic [WIDTH-1:0]  s1;
  logic [READ_LATENCY-1:0] vq;

  assign run       = (state == RUN);
  assign init_busy = ~run;
  assign w_in      = ({1'b0, W0_addr} < DEPTH_X);
  assign r_in      = ({1'b0, R0_addr} < DEPTH_X);
  assign rd_fire   = run & R0_en;
  assign arr_re    = rd_fire & r_in;

  // fill FSM and clear counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next state; array write port owned by the fill during CLEAR
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    arr_we    = 1'b0;
    arr_waddr = W0_addr;
    arr_wdata = W0_data;
    arr_wmask = W0_mask;
    unique case (1'b1)
      (state == CLEAR): begin
        arr_we    = 1'b1;
        arr_waddr = cnt;
        arr_wdata = '0;
        arr_wmask = '1;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      (state == RUN): begin
        arr_we = W0_en & w_in;
      end
      default: ;
    endcase
  end

  mem_1r1w_array #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .MASK_GRAN (MASK_GRAN)
  ) u_array (
    .clk   (clock),
    .rst   (reset),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .wmask (arr_wmask),
    .re    (arr_re),
    .raddr (R0_addr),
    .rdata (rd_q)
  );

  // out-of-range reads resolve to zero; flag tracks the issued read
  always_ff @(posedge clock) begin
    if (reset) begin
      oor_q <= 1'b0;
    end else if (rd_fire) begin
      oor_q <= ~r_in;
    end
  end

`ifdef MEM_1R1W_BYPASS_EN
  logic [WIDTH-1:0] wbm;
  logic             hit;
  logic [WIDTH-1:0] bm_q;
  logic [WIDTH-1:0] bd_q;

  assign hit = W0_en & w_in & r_in & (W0_addr == R0_addr);

  // expand lane mask to a bit mask for the merge
  always_comb begin
    wbm = '0;
    for (int i = 0; i < MASK_W; i++) begin
      wbm[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{W0_mask[i]}};
    end
  end

  // capture same-address write at issue for merge with old word
  always_ff @(posedge clock) begin
    if (reset) begin
      bm_q <= '0;
      bd_q <= '0;
    end else if (rd_fire) begin
      bm_q <= hit ? wbm : '0;
      bd_q <= W0_data;
    end
  end

  assign s1 = oor_q ? '0 : ((rd_q & ~bm_q) | (bd_q & bm_q));
`else
  assign s1 = oor_q ? '0 : rd_q;
`endif

  // valid strobe shift chain, cleared on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      vq <= '0;
    end else begin
      vq[0] <= rd_fire;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vq[k] <= vq[k-1];
      end
    end
  end

  assign R0_valid = vq[READ_LATENCY-1];

  if (READ_LATENCY == 1) begin : g_lat1
    assign R0_data = s1;
  end else begin : g_latn
    logic [WIDTH-1:0] dq [1:READ_LATENCY-1];

    // data stages advance only with their valid, so output holds
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int k = 1; k < READ_LATENCY; k++) begin
          dq[k] <= '0;
        end
      end else begin
        if (vq[0]) begin
          dq[1] <= s1;
        end
        for (int k = 2; k < READ_LATENCY; k++) begin
          if (vq[k-1]) begin
            dq[k] <= dq[k-1];
          end
        end
      end
    end

    assign R0_data = dq[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_mem_1r1w_pipe.sv
// Directed bench for mem_1r1w_pipe at read latencies 1, 2 and 3.
// Three instances share stimulus; outputs checked every cycle.
module tb_mem_1r1w_pipe;

  logic        clock;
  logic        reset;
  logic [5:0]  R0_addr;
  logic        R0_en;
  logic [5:0]  W0_addr;
  logic        W0_en;
  logic [63:0] W0_data;
  logic [7:0]  W0_mask;

  logic [2:0]       r_valid;
  logic [2:0][63:0] r_data;
  logic [2:0]       bsy;

  int total;
  int passed;
  int fails;
  int n;

  logic        rd_ok;
  logic [63:0] rd_exp;
  logic        hist_v [3];
  logic [63:0] hist_d [3];
  logic [63:0] last_d [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_1r1w_pipe #(
      .DEPTH        (48),
      .WIDTH        (64),
      .MASK_GRAN    (8),
      .READ_LATENCY (g + 1)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .R0_addr   (R0_addr),
      .R0_en     (R0_en),
      .R0_data   (r_data[g]),
      .R0_valid  (r_valid[g]),
      .W0_addr   (W0_addr),
      .W0_en     (W0_en),
      .W0_data   (W0_data),
      .W0_mask   (W0_mask),
      .init_busy (bsy[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid_L%0d", i + 1), 64'(r_valid[i]), 64'(hist_v[i]));
      if (hist_v[i]) begin
        chk($sformatf("data_L%0d", i + 1), r_data[i], hist_d[i]);
        last_d[i] = hist_d[i];
      end else begin
        chk($sformatf("hold_L%0d", i + 1), r_data[i], last_d[i]);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    for (int k = 2; k > 0; k--) begin
      hist_v[k] = hist_v[k-1];
      hist_d[k] = hist_d[k-1];
    end
    hist_v[0] = R0_en & rd_ok;
    hist_d[0] = rd_exp;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        hist_v[k] = 1'b0;
        last_d[k] = '0;
      end
    end
    #1;
    mon();
  endtask

  task automatic rd(input logic [5:0] a, input logic [63:0] e);
    R0_en   = 1'b1;
    R0_addr = a;
    rd_ok   = 1'b1;
    rd_exp  = e;
  endtask

  task automatic wr(input logic [5:0] a, input logic [63:0] d,
                    input logic [7:0] m);
    W0_en   = 1'b1;
    W0_addr = a;
    W0_data = d;
    W0_mask = m;
  endtask

  task automatic idle();
    R0_en = 1'b0;
    W0_en = 1'b0;
    rd_ok = 1'b0;
  endtask

  task automatic fill_wait();
    n = 0;
    while (bsy[0] && n < 200) begin
      n++;
      step();
    end
    chk("fill_cycles", 64'(n), 64'd48);
    chk("busy_all_low", 64'(bsy), 64'd0);
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    fails   = 0;
    reset   = 1'b1;
    R0_en   = 1'b0;
    R0_addr = '0;
    W0_en   = 1'b0;
    W0_addr = '0;
    W0_data = '0;
    W0_mask = '0;
    rd_ok   = 1'b0;
    rd_exp  = '0;
    for (int k = 0; k < 3; k++) begin
      hist_v[k] = 1'b0;
      hist_d[k] = '0;
      last_d[k] = '0;
    end
    #1;
    repeat (3) step();
    chk("busy_in_reset", 64'(bsy), 64'h7);
    reset = 1'b0;

    // requests during fill are dropped
    R0_en = 1'b1;
    R0_addr = 6'd3;
    rd_ok = 1'b0;
    wr(6'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    fill_wait();
    idle();

    // every word reads zero after fill
    for (int a = 0; a < 48; a++) begin
      rd(6'(a), 64'h0);
      step();
    end
    idle();
    repeat (4) step();

    // masked partial overwrite
    wr(6'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
    step();
    wr(6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    step();
    idle();
    rd(6'd5, 64'h0123_4567_FFFF_FFFF);
    step();
    idle();
    repeat (4) step();

    // independent write elsewhere, then mask-0 write is a no-op
    wr(6'd9, 64'hDEAD_BEEF_0000_1234, 8'hFF);
    rd(6'd5, 64'h0123_4567_FFFF_FFFF);
    step();
    idle();
    wr(6'd5, 64'h0, 8'h00);
    step();
    idle();
    rd(6'd5, 64'h0123_4567_FFFF_FFFF);
    step();
    rd(6'd9, 64'hDEAD_BEEF_0000_1234);
    step();
    idle();
    repeat (4) step();

    // same-cycle read and write to one address
    wr(6'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
`ifdef MEM_1R1W_BYPASS_EN
    rd(6'd7, 64'hAAAA_AAAA_AAAA_AAAA);
`else
    rd(6'd7, 64'h0);
`endif
    step();
    idle();
    rd(6'd7, 64'hAAAA_AAAA_AAAA_AAAA);
    step();
    idle();
    repeat (4) step();

    // back-to-back reads stream out in order
    wr(6'd0, 64'h1111_1111_1111_1111, 8'hFF);
    step();
    wr(6'd1, 64'h2222_2222_2222_2222, 8'hFF);
    step();
    wr(6'd2, 64'h3333_3333_3333_3333, 8'hFF);
    step();
    idle();
    rd(6'd0, 64'h1111_1111_1111_1111);
    step();
    rd(6'd1, 64'h2222_2222_2222_2222);
    step();
    rd(6'd2, 64'h3333_3333_3333_3333);
    step();
    idle();
    repeat (5) step();
    chk("hold_after_burst_L2", r_data[1], 64'h3333_3333_3333_3333);

    // out-of-range write dropped, read returns zero
    wr(6'd50, 64'hFFFF_0000_FFFF_0000, 8'hFF);
    step();
    idle();
    rd(6'd50, 64'h0);
    step();
    idle();
    repeat (4) step();

    // reset with a read in flight, then reset again mid-fill
    wr(6'd10, 64'h55, 8'hFF);
    step();
    idle();
    rd(6'd10, 64'h55);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (20) step();
    chk("busy_mid_fill", 64'(bsy), 64'h7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    fill_wait();
    rd(6'd10, 64'h0);
    step();
    idle();
    repeat (4) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
